// File: rtl/calc_ctrl_fsm.sv
// rtl/calc_ctrl_fsm.sv - keypad calculator control FSM sequencing operand entry and ALU handshake.
// Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_ctrl_fsm #(
  parameter int DIGITS         = 4,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digitValid,
  input  logic [3:0]       digitIn,
  input  logic             opRecived,
  input  logic [1:0]       opCode,
  input  logic             eqRecived,
  input  logic             clrRecived,
  input  logic             aluDone,
  input  logic             aluErr,
  output logic [2:0]       salida,
  output logic [CNT_W-1:0] digitCount,
  output logic [1:0]       opLatched,
  output logic             loadA,
  output logic             loadB,
  output logic             aluStart,
  output logic             newOperation,
  output logic             clrRegs,
  output logic             errorFlag
);

  localparam logic [2:0] S_WAIT_NUM1   = 3'd0;
  localparam logic [2:0] S_WAIT_NUM2   = 3'd1;
  localparam logic [2:0] S_CALC        = 3'd2;
  localparam logic [2:0] S_SHOW_RESULT = 3'd3;
  localparam logic [2:0] S_ERROR       = 3'd4;

  if (DIGITS < 1 || DIGITS > 15 || (1 << CNT_W) <= DIGITS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("calc_ctrl_fsm: illegal parameter combination");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       pend_q, pend_d;
  logic             chain_q, chain_d;
  logic             load_a_q, load_a_d;
  logic             load_b_q, load_b_d;
  logic             alu_start_q, alu_start_d;
  logic             new_op_q, new_op_d;
  logic             clr_regs_q, clr_regs_d;
  logic             error_flag_q, error_flag_d;
  logic             digit_ok;
  logic             digit_room;
  logic             alu_timeout;

`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;

  // Counter restarts on every aluStart and expires after TIMEOUT_CYCLES cycles in CALC.
  always_comb begin
    tmo_d = tmo_q;
    if (alu_start_d) begin
      tmo_d = '0;
    end else if (state_q == S_CALC) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign alu_timeout = (state_q == S_CALC) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign alu_timeout = 1'b0;
`endif

  assign digit_ok   = digitValid && (digitIn <= 4'd9);
  assign digit_room = cnt_q < CNT_W'(DIGITS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    pend_d      = pend_q;
    chain_d     = chain_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    alu_start_d = 1'b0;
    new_op_d    = 1'b0;
    clr_regs_d  = 1'b0;

    if (clrRecived) begin
      state_d    = S_WAIT_NUM1;
      clr_regs_d = 1'b1;
      cnt_d      = '0;
      chain_d    = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_NUM1: begin
          if (opRecived) begin
            if (cnt_q != '0) begin
              op_d    = opCode;
              state_d = S_WAIT_NUM2;
              cnt_d   = '0;
            end
          end else if (!eqRecived && digit_ok && digit_room) begin
            load_a_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_NUM2: begin
          if (opRecived) begin
            if (cnt_q == '0) begin
              op_d = opCode;
            end else begin
              alu_start_d = 1'b1;
              state_d     = S_CALC;
              chain_d     = 1'b1;
              pend_d      = opCode;
            end
          end else if (eqRecived) begin
            if (cnt_q != '0) begin
              alu_start_d = 1'b1;
              state_d     = S_CALC;
            end
          end else if (digit_ok && digit_room) begin
            load_b_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
        S_CALC: begin
          if (aluDone) begin
            if (aluErr) begin
              state_d = S_ERROR;
            end else if (chain_q) begin
              op_d     = pend_q;
              new_op_d = 1'b1;
              cnt_d    = '0;
              chain_d  = 1'b0;
              state_d  = S_WAIT_NUM2;
            end else begin
              state_d = S_SHOW_RESULT;
            end
          end else if (alu_timeout) begin
            state_d = S_ERROR;
          end
        end
        S_SHOW_RESULT: begin
          if (opRecived) begin
            op_d     = opCode;
            new_op_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT_NUM2;
          end else if (eqRecived) begin
            alu_start_d = 1'b1;
            state_d     = S_CALC;
          end else if (digit_ok) begin
            // A fresh digit after a result starts a new calculation from scratch.
            clr_regs_d = 1'b1;
            load_a_d   = 1'b1;
            cnt_d      = CNT_W'(1);
            state_d    = S_WAIT_NUM1;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d    = S_WAIT_NUM1;
          clr_regs_d = 1'b1;
          cnt_d      = '0;
          chain_d    = 1'b0;
        end
      endcase
    end

    error_flag_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_NUM1;
      cnt_q        <= '0;
      op_q         <= '0;
      pend_q       <= '0;
      chain_q      <= 1'b0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      alu_start_q  <= 1'b0;
      new_op_q     <= 1'b0;
      clr_regs_q   <= 1'b0;
      error_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      pend_q       <= pend_d;
      chain_q      <= chain_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      alu_start_q  <= alu_start_d;
      new_op_q     <= new_op_d;
      clr_regs_q   <= clr_regs_d;
      error_flag_q <= error_flag_d;
    end
  end

  assign salida       = state_q;
  assign digitCount   = cnt_q;
  assign opLatched    = op_q;
  assign loadA        = load_a_q;
  assign loadB        = load_b_q;
  assign aluStart     = alu_start_q;
  assign newOperation = new_op_q;
  assign clrRegs      = clr_regs_q;
  assign errorFlag    = error_flag_q;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// tb/tb_calc_ctrl_fsm.sv - randomized and directed bench for calc_ctrl_fsm against an event-level model.
module tb_calc_ctrl_fsm;
  localparam int DIGITS = 4;
  localparam int CNT_W  = 4;
  localparam int TMO    = 8;

  logic       clk = 1'b0;
  logic       rst, digitValid, opRecived, eqRecived, clrRecived, aluDone, aluErr;
  logic [3:0] digitIn;
  logic [1:0] opCode;
  logic [2:0] salida;
  logic [CNT_W-1:0] digitCount;
  logic [1:0] opLatched;
  logic       loadA, loadB, aluStart, newOperation, clrRegs, errorFlag;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model of the calculator in spec terms: 0=num1 1=num2 2=calc 3=show 4=error.
  int m_state, m_cnt, m_op, m_pend, m_tmo;
  bit m_chain, m_la, m_lb, m_start, m_newop, m_clr;

  calc_ctrl_fsm #(.DIGITS(DIGITS), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .digitValid(digitValid), .digitIn(digitIn),
    .opRecived(opRecived), .opCode(opCode), .eqRecived(eqRecived),
    .clrRecived(clrRecived), .aluDone(aluDone), .aluErr(aluErr),
    .salida(salida), .digitCount(digitCount), .opLatched(opLatched),
    .loadA(loadA), .loadB(loadB), .aluStart(aluStart),
    .newOperation(newOperation), .clrRegs(clrRegs), .errorFlag(errorFlag)
  );

  always #5 clk = ~clk;

  wire [14:0] dut_vec = {salida, digitCount, opLatched, loadA, loadB, aluStart, newOperation, clrRegs, errorFlag};

  function automatic logic [14:0] exp_vec();
    return {3'(m_state), 4'(m_cnt), 2'(m_op), m_la, m_lb, m_start, m_newop, m_clr, (m_state == 4)};
  endfunction

  task automatic start_calc();
    m_start = 1;
    m_state = 2;
    m_tmo = 0;
  endtask

  task automatic model_update(input bit dv, input int d, input bit op, input int oc,
                              input bit eq, input bit clr, input bit done, input bit err, input bit r);
    m_la = 0; m_lb = 0; m_start = 0; m_newop = 0; m_clr = 0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_op = 0; m_pend = 0; m_chain = 0; m_tmo = 0;
    end else if (clr) begin
      m_state = 0; m_clr = 1; m_cnt = 0; m_chain = 0;
    end else if (m_state == 2) begin
      if (done && err) m_state = 4;
      else if (done && m_chain) begin
        m_op = m_pend; m_newop = 1; m_cnt = 0; m_chain = 0; m_state = 1;
      end else if (done) m_state = 3;
      else begin
        m_tmo++;
`ifdef CALC_TIMEOUT_EN
        if (m_tmo == TMO) m_state = 4;
`endif
      end
    end else if (m_state == 4) begin
      m_state = 4;
    end else if (op) begin
      if (m_state == 0 && m_cnt > 0) begin
        m_op = oc; m_state = 1; m_cnt = 0;
      end else if (m_state == 1 && m_cnt == 0) m_op = oc;
      else if (m_state == 1) begin
        m_chain = 1; m_pend = oc; start_calc();
      end else if (m_state == 3) begin
        m_op = oc; m_newop = 1; m_cnt = 0; m_state = 1;
      end
    end else if (eq) begin
      if ((m_state == 1 && m_cnt > 0) || m_state == 3) start_calc();
    end else if (dv && d <= 9) begin
      if (m_state == 3) begin
        m_clr = 1; m_la = 1; m_cnt = 1; m_state = 0;
      end else if (m_cnt < DIGITS) begin
        if (m_state == 0) m_la = 1; else m_lb = 1;
        m_cnt++;
      end
    end
  endtask

  task automatic drive(input bit dv, input int d, input bit op, input int oc,
                       input bit eq, input bit clr, input bit done, input bit err, input bit r);
    @(negedge clk);
    digitValid = dv; digitIn = 4'(d); opRecived = op; opCode = 2'(oc);
    eqRecived = eq; clrRecived = clr; aluDone = done; aluErr = err; rst = r;
    model_update(dv, d, op, oc, eq, clr, done, err, r);
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input int d); drive(1, d, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic oper(input int oc); drive(0, 0, 1, oc, 0, 0, 0, 0, 0); endtask
  task automatic equals(); drive(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic clear(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic done(input bit err); drive(0, 0, 0, 0, 0, 0, 1, err, 0); endtask
  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    total_cnt++;
    if (dut_vec !== 15'd0) $display("FAIL reset_state got %h want %h", dut_vec, 15'd0);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_basic();
    digit(1); digit(2);
    total_cnt++;
    if (dut_vec !== exp_vec() || digitCount !== 4'd2 || loadA !== 1'b1)
      $display("FAIL basic_digits got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    oper(2);
    total_cnt++;
    if (dut_vec !== exp_vec() || opLatched !== 2'd2 || salida !== 3'd1)
      $display("FAIL basic_op got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    digit(3);
    total_cnt++;
    if (dut_vec !== exp_vec() || loadB !== 1'b1) $display("FAIL basic_loadb got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    equals();
    total_cnt++;
    if (dut_vec !== exp_vec() || aluStart !== 1'b1 || salida !== 3'd2)
      $display("FAIL basic_start got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    done(0);
    total_cnt++;
    if (dut_vec !== exp_vec() || salida !== 3'd3) $display("FAIL basic_show got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    clear();
    for (int i = 1; i <= 5; i++) begin
      digit(i);
      total_cnt++;
      if (dut_vec !== exp_vec() || loadA !== (i <= DIGITS))
        $display("FAIL sat_digit%0d got %h want %h", i, dut_vec, exp_vec());
      else pass_cnt++;
    end
    digit(12);
    total_cnt++;
    if (dut_vec !== exp_vec() || digitCount !== 4'd4 || loadA !== 1'b0)
      $display("FAIL sat_bad_digit got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_chain();
    clear(); digit(5); oper(0); digit(2); oper(1);
    total_cnt++;
    if (dut_vec !== exp_vec() || aluStart !== 1'b1) $display("FAIL chain_start got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    done(0);
    total_cnt++;
    if (dut_vec !== exp_vec() || newOperation !== 1'b1 || opLatched !== 2'd1 || salida !== 3'd1 || digitCount !== 4'd0)
      $display("FAIL chain_done got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_show();
    digit(3); equals(); done(0); equals();
    total_cnt++;
    if (dut_vec !== exp_vec() || aluStart !== 1'b1 || salida !== 3'd2)
      $display("FAIL repeat_eq got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    done(0); digit(7);
    total_cnt++;
    if (dut_vec !== exp_vec() || clrRegs !== 1'b1 || loadA !== 1'b1 || salida !== 3'd0 || digitCount !== 4'd1)
      $display("FAIL show_digit got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    drive(1, 4, 1, 3, 0, 0, 0, 0, 0);
    total_cnt++;
    if (dut_vec !== exp_vec() || loadA !== 1'b0 || opLatched !== 2'd3 || salida !== 3'd1)
      $display("FAIL op_beats_digit got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_error();
    digit(4); equals(); done(1);
    total_cnt++;
    if (dut_vec !== exp_vec() || salida !== 3'd4 || errorFlag !== 1'b1)
      $display("FAIL err_enter got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    digit(1); oper(2); equals(); done(0);
    total_cnt++;
    if (dut_vec !== exp_vec() || salida !== 3'd4) $display("FAIL err_sticky got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
    clear();
    total_cnt++;
    if (dut_vec !== exp_vec() || salida !== 3'd0 || clrRegs !== 1'b1 || errorFlag !== 1'b0)
      $display("FAIL err_clear got %h want %h", dut_vec, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    digit(1); oper(0); digit(2); equals();
    for (int i = 1; i <= TMO + 2; i++) begin
      idle();
      total_cnt++;
`ifdef CALC_TIMEOUT_EN
      if (dut_vec !== exp_vec() || salida !== ((i >= TMO) ? 3'd4 : 3'd2))
`else
      if (dut_vec !== exp_vec() || salida !== 3'd2)
`endif
        $display("FAIL timeout_cyc%0d got %h want %h", i, dut_vec, exp_vec());
      else pass_cnt++;
    end
    clear(); digit(1); oper(0); digit(2); equals(); idle();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    total_cnt++;
    if (dut_vec !== 15'd0 || dut_vec !== exp_vec()) $display("FAIL rst_mid_calc got %h want %h", dut_vec, 15'd0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 5) == 0, $urandom_range(0, 3),
            $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
      total_cnt++;
      if (dut_vec !== exp_vec()) begin
        if (errs < 10) $display("FAIL random_step%0d got %h want %h", i, dut_vec, exp_vec());
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    {rst, digitValid, opRecived, eqRecived, clrRecived, aluDone, aluErr} = '0;
    digitIn = '0; opCode = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_chain();
    test_show();
    test_simultaneous();
    test_error();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/calc_ctrl_fsm.md
Name: calc_ctrl_fsm

Overview:
Parametrised control FSM for the keypad calculator. It sequences operand entry with a bounded digit count and latches the operator. It handshakes with the ALU through aluStart/aluDone and supports chained operations, repeat-equals, clear and an error state. It sits between the keypad decoder and the operand registers/ALU, and drives their load strobes.

Parameters:
DIGITS, 4, max digits accepted per operand (1..15)
CNT_W, 4, width of digitCount; must satisfy 2^CNT_W > DIGITS
TIMEOUT_CYCLES, 64, ALU timeout in cycles (used only with CALC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
digitValid  in  1  one-cycle pulse, digit key pressed
digitIn  in  4  digit value; values >9 are ignored
opRecived  in  1  one-cycle pulse, operator key pressed
opCode  in  2  operator code, sampled with opRecived
eqRecived  in  1  one-cycle pulse, '=' key pressed
clrRecived  in  1  one-cycle pulse, clear key pressed
aluDone  in  1  one-cycle pulse, ALU result valid
aluErr  in  1  ALU error qualifier, sampled with aluDone
salida  out  3  current state code
digitCount  out  CNT_W  digits entered for the current operand
opLatched  out  2  latched operator
loadA  out  1  pulse: shift digitIn into operand A
loadB  out  1  pulse: shift digitIn into operand B
aluStart  out  1  pulse: start ALU with opLatched
newOperation  out  1  pulse: previous result reused as operand A
clrRegs  out  1  pulse: clear operand/result registers
errorFlag  out  1  level: FSM in ERROR

Behaviour:
- All outputs are registered; a response appears the cycle after the causing input. Pulse outputs are high for exactly one cycle.
- Reset values: salida=0, digitCount=0, opLatched=0, all pulses 0, errorFlag=0. Reset is asserted synchronously by rst and has top priority; mid-calculation it aborts to WAIT_NUM1 with no aluStart.
- State codes: WAIT_NUM1=0, WAIT_NUM2=1, CALC=2, SHOW_RESULT=3, ERROR=4. Codes 5-7 are illegal and return to WAIT_NUM1 with clrRegs.
- Priority inside each state: clrRecived > opRecived > eqRecived > digitValid.
- clrRecived in any state: go to WAIT_NUM1, pulse clrRegs, set digitCount=0, errorFlag=0, clear the chain flag.
- Valid digit: digitIn<=9 and digitCount<DIGITS. It pulses loadA (WAIT_NUM1) or loadB (WAIT_NUM2) and increments digitCount. At digitCount==DIGITS the digit is dropped and the count saturates.
- WAIT_NUM1:
  - opRecived with digitCount>0: latch opCode, go to WAIT_NUM2, digitCount=0.
  - opRecived with digitCount==0: ignored.
  - eqRecived: ignored.
- WAIT_NUM2:
  - opRecived with digitCount==0: overwrite opLatched, stay.
  - opRecived with digitCount>0: chain. Pulse aluStart, go to CALC, set chain flag, hold the new opCode in a pending register.
  - eqRecived with digitCount>0: pulse aluStart, go to CALC.
  - eqRecived with digitCount==0: ignored.
- CALC: every key except clr is ignored.
  - aluDone with aluErr=1: go to ERROR.
  - aluDone with aluErr=0 and chain flag set: opLatched=pending op, pulse newOperation, digitCount=0, clear chain flag, go to WAIT_NUM2.
  - aluDone with aluErr=0 and chain flag clear: go to SHOW_RESULT.
- SHOW_RESULT:
  - opRecived: latch opCode, pulse newOperation, digitCount=0, go to WAIT_NUM2.
  - eqRecived: pulse aluStart, go to CALC. This is repeat-equals with the same B and op.
  - Valid digit: pulse clrRegs and loadA in the same cycle, digitCount=1, go to WAIT_NUM1.
- ERROR: errorFlag=1; only clrRecived or rst exits.
- Simultaneous digitValid and opRecived: the operator wins and the digit is dropped.

Optional Feature:
CALC_TIMEOUT_EN
- Defined: a counter starts at aluStart. If aluDone has not arrived when the counter reaches TIMEOUT_CYCLES, go to ERROR and set errorFlag. A late aluDone in ERROR is ignored.
- Undefined: CALC waits for aluDone indefinitely; the counter logic is absent.

Test Plan:
- Reset. Digits 1,2 / op=2 / digit 3 / eq / aluDone aluErr=0 -> loadA x2 (digitCount 1,2), opLatched=2, loadB x1, one aluStart, salida 0→1→2→3.
- Digits 1,2,3,4,5 with DIGITS=4 -> four loadA pulses, fifth dropped, digitCount=4. digitIn=12 -> no loadA.
- Chain: digit 5 / op=0 / digit 2 / op=1 / aluDone(ok) -> aluStart, then newOperation, opLatched=1, salida=1, digitCount=0.
- SHOW_RESULT then eq -> aluStart, salida=2. SHOW_RESULT then digit 7 -> clrRegs and loadA same cycle, salida=0, digitCount=1.
- aluDone with aluErr=1 -> salida=4, errorFlag=1. Digits/op/eq ignored. clr -> salida=0, clrRegs, errorFlag=0.
- CALC_TIMEOUT_EN, TIMEOUT_CYCLES=8, no aluDone -> salida=4 after 8 cycles. Without the macro -> salida stays 2. rst mid-CALC -> salida=0, no pulses.
